reorder_buffer: RTL and testbench



---
 rtl/reorder_buffer_pkg.sv | 20 ++
 rtl/reorder_buffer_if.sv | 44 ++++
 rtl/reorder_buffer.sv | 104 ++++++++++
 tb/tb_reorder_buffer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: row layout, ROB index and physical register address.
package reorder_buffer_pkg;

    localparam int unsigned ROB_DEPTH     = 16;
    localparam int unsigned ROB_IDX_W     = 4;
    localparam int unsigned PREG_W        = 7;
    localparam int unsigned ROB_CMP_PORTS = 3;

    typedef logic [ROB_IDX_W-1:0] rob_idx;
    typedef logic [PREG_W-1:0]    preg_addr;

    typedef struct packed {
        logic     valid;
        preg_addr preg_dst;
        preg_addr old_preg_dst;
        logic     complete;
        logic     reg_write;
    } rob_row_struct;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, completion and retire signals of the reorder buffer.
// The master side is the pipeline; the slave side is the ROB.
interface reorder_buffer_if
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned CMP_PORTS = ROB_CMP_PORTS
) ();

    logic                     alloc_valid;
    logic                     alloc_ready;
    preg_addr                 alloc_preg_dst;
    preg_addr                 alloc_old_preg_dst;
    logic                     alloc_reg_write;
    rob_idx                   alloc_rob_num;

    logic [CMP_PORTS-1:0]     cmp_valid;
    rob_idx [CMP_PORTS-1:0]   cmp_rob_num;

    logic                     retire_valid;
    preg_addr                 retire_preg_dst;
    preg_addr                 retire_old_preg_dst;
    logic                     retire_reg_write;

    logic [ROB_IDX_W:0]       count;
    logic                     empty;
    logic                     full;

    modport master (
        output alloc_valid, alloc_preg_dst, alloc_old_preg_dst, alloc_reg_write,
        output cmp_valid, cmp_rob_num,
        input  alloc_ready, alloc_rob_num,
        input  retire_valid, retire_preg_dst, retire_old_preg_dst, retire_reg_write,
        input  count, empty, full
    );

    modport slave (
        input  alloc_valid, alloc_preg_dst, alloc_old_preg_dst, alloc_reg_write,
        input  cmp_valid, cmp_rob_num,
        output alloc_ready, alloc_rob_num,
        output retire_valid, retire_preg_dst, retire_old_preg_dst, retire_reg_write,
        output count, empty, full
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order alloc at tail, out-of-order completion,
// in-order single retire at head with a registered retire pulse.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = ROB_DEPTH,
    parameter int unsigned CMP_PORTS = ROB_CMP_PORTS
) (
    input  logic           clk,
    input  logic           rst_n,
    reorder_buffer_if.slave rob
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    typedef logic [IdxW:0] ptr_t;

    rob_row_struct rows_q [DEPTH];
    rob_row_struct rows_d [DEPTH];
    ptr_t          head_q, head_d;
    ptr_t          tail_q, tail_d;

    logic          retire_valid_q;
    preg_addr      retire_preg_dst_q;
    preg_addr      retire_old_preg_dst_q;
    logic          retire_reg_write_q;

    logic          full;
    logic          do_alloc;
    logic          do_retire;
    rob_row_struct head_row;

    assign full      = (head_q[IdxW-1:0] == tail_q[IdxW-1:0]) && (head_q[IdxW] != tail_q[IdxW]);
    assign head_row  = rows_q[head_q[IdxW-1:0]];
    assign do_retire = head_row.valid && head_row.complete;
    // A same-cycle retire does not free a slot for alloc; full stalls for one cycle.
    assign do_alloc  = rob.alloc_valid && !full;

    always_comb begin
        rows_d = rows_q;
        head_d = head_q;
        tail_d = tail_q;

        for (int unsigned p = 0; p < CMP_PORTS; p++) begin
            if (rob.cmp_valid[p] && rows_q[rob.cmp_rob_num[p]].valid) begin
                rows_d[rob.cmp_rob_num[p]].complete = 1'b1;
            end
        end

        if (do_retire) begin
            rows_d[head_q[IdxW-1:0]].valid    = 1'b0;
            rows_d[head_q[IdxW-1:0]].complete = 1'b0;
            head_d                            = head_q + ptr_t'(1);
        end

        // The tail row is never valid while not full, so this cannot clobber a completion.
        if (do_alloc) begin
            rows_d[tail_q[IdxW-1:0]] = '{
                valid:        1'b1,
                preg_dst:     rob.alloc_preg_dst,
                old_preg_dst: rob.alloc_old_preg_dst,
                complete:     1'b0,
                reg_write:    rob.alloc_reg_write
            };
            tail_d = tail_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q                <= '0;
            tail_q                <= '0;
            retire_valid_q        <= 1'b0;
            retire_preg_dst_q     <= '0;
            retire_old_preg_dst_q <= '0;
            retire_reg_write_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                rows_q[i] <= '0;
            end
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            rows_q         <= rows_d;
            retire_valid_q <= do_retire;
            if (do_retire) begin
                retire_preg_dst_q     <= head_row.preg_dst;
                retire_old_preg_dst_q <= head_row.old_preg_dst;
                retire_reg_write_q    <= head_row.reg_write;
            end
        end
    end

    assign rob.alloc_ready         = !full;
    assign rob.alloc_rob_num       = tail_q[IdxW-1:0];
    assign rob.count               = tail_q - head_q;
    assign rob.empty               = (head_q == tail_q);
    assign rob.full                = full;
    assign rob.retire_valid        = retire_valid_q;
    assign rob.retire_preg_dst     = retire_preg_dst_q;
    assign rob.retire_old_preg_dst = retire_old_preg_dst_q;
    assign rob.retire_reg_write    = retire_reg_write_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, single retire, in-order retire after
// out-of-order completion, full/wrap, multi-port completion, steady state and mid-run reset.
module tb_reorder_buffer;

    logic clk;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    reorder_buffer_if #(.CMP_PORTS(3)) rob_if ();

    reorder_buffer #(
        .DEPTH    (16),
        .CMP_PORTS(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rob  (rob_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        rob_if.alloc_valid        = 1'b0;
        rob_if.alloc_preg_dst     = '0;
        rob_if.alloc_old_preg_dst = '0;
        rob_if.alloc_reg_write    = 1'b0;
        rob_if.cmp_valid          = '0;
        rob_if.cmp_rob_num        = '0;
    endtask

    task automatic set_alloc(input logic v, input logic [6:0] p, input logic [6:0] o,
                             input logic rw);
        rob_if.alloc_valid        = v;
        rob_if.alloc_preg_dst     = p;
        rob_if.alloc_old_preg_dst = o;
        rob_if.alloc_reg_write    = rw;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (rob_if.count !== 5'd0) begin
            $display("FAIL reset_count got %0d want 0", rob_if.count); miscompares++;
        end
        vectors++;
        if (rob_if.empty !== 1'b1 || rob_if.full !== 1'b0) begin
            $display("FAIL reset_flags got empty=%b full=%b want 1/0", rob_if.empty, rob_if.full);
            miscompares++;
        end
        vectors++;
        if (rob_if.alloc_ready !== 1'b1 || rob_if.alloc_rob_num !== 4'd0) begin
            $display("FAIL reset_alloc got ready=%b num=%0d want 1/0",
                     rob_if.alloc_ready, rob_if.alloc_rob_num);
            miscompares++;
        end
        vectors++;
        if (rob_if.retire_valid !== 1'b0 || rob_if.retire_old_preg_dst !== 7'd0 ||
            rob_if.retire_preg_dst !== 7'd0 || rob_if.retire_reg_write !== 1'b0) begin
            $display("FAIL reset_retire got v=%b p=%0d o=%0d rw=%b want all 0",
                     rob_if.retire_valid, rob_if.retire_preg_dst,
                     rob_if.retire_old_preg_dst, rob_if.retire_reg_write);
            miscompares++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_alloc(1'b1, 7'd32, 7'd5, 1'b1);
        tick();
        idle();
        vectors++;
        if (rob_if.count !== 5'd1) begin
            $display("FAIL single_count1 got %0d want 1", rob_if.count); miscompares++;
        end
        rob_if.cmp_valid[0]   = 1'b1;
        rob_if.cmp_rob_num[0] = 4'd0;
        tick();
        idle();
        vectors++;
        if (rob_if.retire_valid !== 1'b0) begin
            $display("FAIL single_early_retire got %b want 0", rob_if.retire_valid); miscompares++;
        end
        tick();
        vectors++;
        if (rob_if.retire_valid !== 1'b1 || rob_if.retire_preg_dst !== 7'd32 ||
            rob_if.retire_old_preg_dst !== 7'd5 || rob_if.retire_reg_write !== 1'b1) begin
            $display("FAIL single_retire got v=%b p=%0d o=%0d rw=%b want 1/32/5/1",
                     rob_if.retire_valid, rob_if.retire_preg_dst,
                     rob_if.retire_old_preg_dst, rob_if.retire_reg_write);
            miscompares++;
        end
        vectors++;
        if (rob_if.count !== 5'd0 || rob_if.empty !== 1'b1) begin
            $display("FAIL single_count0 got %0d empty=%b want 0/1", rob_if.count, rob_if.empty);
            miscompares++;
        end
        tick();
        vectors++;
        if (rob_if.retire_valid !== 1'b0) begin
            $display("FAIL single_pulse_width got %b want 0", rob_if.retire_valid); miscompares++;
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(1'b1, 7'(10 + i), 7'(20 + i), 1'b1);
            tick();
        end
        idle();
        vectors++;
        if (rob_if.count !== 5'd3) begin
            $display("FAIL ooo_count got %0d want 3", rob_if.count); miscompares++;
        end
        for (int r = 2; r >= 1; r--) begin
            rob_if.cmp_valid[0]   = 1'b1;
            rob_if.cmp_rob_num[0] = 4'(r);
            tick();
            idle();
            tick();
            vectors++;
            if (rob_if.retire_valid !== 1'b0) begin
                $display("FAIL ooo_no_retire_row%0d got %b want 0", r, rob_if.retire_valid);
                miscompares++;
            end
        end
        rob_if.cmp_valid[0]   = 1'b1;
        rob_if.cmp_rob_num[0] = 4'd0;
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (rob_if.retire_valid !== 1'b1 || rob_if.retire_preg_dst !== 7'(10 + k)) begin
                $display("FAIL ooo_retire%0d got v=%b p=%0d want 1/%0d",
                         k, rob_if.retire_valid, rob_if.retire_preg_dst, 10 + k);
                miscompares++;
            end
        end
        tick();
        vectors++;
        if (rob_if.retire_valid !== 1'b0 || rob_if.empty !== 1'b1) begin
            $display("FAIL ooo_drained got v=%b empty=%b want 0/1",
                     rob_if.retire_valid, rob_if.empty);
            miscompares++;
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_alloc(1'b1, 7'(i), 7'(i + 64), 1'b0);
            tick();
        end
        vectors++;
        if (rob_if.full !== 1'b1 || rob_if.alloc_ready !== 1'b0 || rob_if.count !== 5'd16) begin
            $display("FAIL full_flags got full=%b ready=%b count=%0d want 1/0/16",
                     rob_if.full, rob_if.alloc_ready, rob_if.count);
            miscompares++;
        end
        set_alloc(1'b1, 7'd99, 7'd77, 1'b1);
        tick();
        vectors++;
        if (rob_if.count !== 5'd16 || rob_if.alloc_rob_num !== 4'd0) begin
            $display("FAIL full_ignored got count=%0d num=%0d want 16/0",
                     rob_if.count, rob_if.alloc_rob_num);
            miscompares++;
        end
        rob_if.cmp_valid[0]   = 1'b1;
        rob_if.cmp_rob_num[0] = 4'd0;
        tick();
        rob_if.cmp_valid = '0;
        tick();
        vectors++;
        if (rob_if.retire_valid !== 1'b1 || rob_if.count !== 5'd15) begin
            $display("FAIL full_retire_stall got v=%b count=%0d want 1/15",
                     rob_if.retire_valid, rob_if.count);
            miscompares++;
        end
        vectors++;
        if (rob_if.alloc_ready !== 1'b1 || rob_if.alloc_rob_num !== 4'd0) begin
            $display("FAIL full_wrap_num got ready=%b num=%0d want 1/0",
                     rob_if.alloc_ready, rob_if.alloc_rob_num);
            miscompares++;
        end
        tick();
        idle();
        vectors++;
        if (rob_if.count !== 5'd16 || rob_if.full !== 1'b1 || rob_if.alloc_rob_num !== 4'd1) begin
            $display("FAIL full_refill got count=%0d full=%b num=%0d want 16/1/1",
                     rob_if.count, rob_if.full, rob_if.alloc_rob_num);
            miscompares++;
        end
    endtask

    task automatic test_multi_cmp();
        do_reset();
        set_alloc(1'b1, 7'd40, 7'd1, 1'b1);
        tick();
        set_alloc(1'b1, 7'd41, 7'd2, 1'b1);
        tick();
        idle();
        rob_if.cmp_valid   = 3'b111;
        rob_if.cmp_rob_num = {4'd0, 4'd0, 4'd0};
        tick();
        idle();
        rob_if.cmp_valid[0]   = 1'b1;
        rob_if.cmp_rob_num[0] = 4'd2;
        tick();
        idle();
        vectors++;
        if (rob_if.retire_valid !== 1'b1 || rob_if.retire_preg_dst !== 7'd40) begin
            $display("FAIL multi_retire0 got v=%b p=%0d want 1/40",
                     rob_if.retire_valid, rob_if.retire_preg_dst);
            miscompares++;
        end
        vectors++;
        if (rob_if.alloc_rob_num !== 4'd2) begin
            $display("FAIL multi_tail got %0d want 2", rob_if.alloc_rob_num); miscompares++;
        end
        set_alloc(1'b1, 7'd42, 7'd3, 1'b1);
        tick();
        idle();
        vectors++;
        if (rob_if.retire_valid !== 1'b0) begin
            $display("FAIL multi_once got %b want 0", rob_if.retire_valid); miscompares++;
        end
        rob_if.cmp_valid[1]   = 1'b1;
        rob_if.cmp_rob_num[1] = 4'd1;
        tick();
        idle();
        tick();
        vectors++;
        if (rob_if.retire_valid !== 1'b1 || rob_if.retire_preg_dst !== 7'd41) begin
            $display("FAIL multi_retire1 got v=%b p=%0d want 1/41",
                     rob_if.retire_valid, rob_if.retire_preg_dst);
            miscompares++;
        end
        tick();
        vectors++;
        if (rob_if.retire_valid !== 1'b0 || rob_if.count !== 5'd1) begin
            $display("FAIL multi_invalid_dropped got v=%b count=%0d want 0/1",
                     rob_if.retire_valid, rob_if.count);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_alloc(1'b1, 7'(i), 7'(i), 1'b1);
            tick();
        end
        idle();
        rob_if.cmp_valid[0]   = 1'b1;
        rob_if.cmp_rob_num[0] = 4'd0;
        tick();
        for (int k = 0; k < 40; k++) begin
            set_alloc(1'b1, 7'(8 + k), 7'(k), 1'b1);
            rob_if.cmp_valid[0]   = 1'b1;
            rob_if.cmp_rob_num[0] = 4'((k + 1) % 16);
            #1;
            vectors++;
            if (rob_if.count !== 5'd8 || rob_if.alloc_rob_num !== 4'((8 + k) % 16)) begin
                $display("FAIL steady_state%0d got count=%0d num=%0d want 8/%0d",
                         k, rob_if.count, rob_if.alloc_rob_num, (8 + k) % 16);
                miscompares++;
            end
            tick();
            vectors++;
            if (rob_if.retire_valid !== 1'b1 || rob_if.retire_preg_dst !== 7'(k)) begin
                $display("FAIL steady_retire%0d got v=%b p=%0d want 1/%0d",
                         k, rob_if.retire_valid, rob_if.retire_preg_dst, k);
                miscompares++;
            end
        end
        idle();
        vectors++;
        if (rob_if.count !== 5'd8) begin
            $display("FAIL steady_final got %0d want 8", rob_if.count); miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(1'b1, 7'(50 + i), 7'(i), 1'b1);
            tick();
        end
        idle();
        rob_if.cmp_valid[0]   = 1'b1;
        rob_if.cmp_rob_num[0] = 4'd0;
        tick();
        // Row 0 would retire at the next edge; reset and other events collide with it.
        rst_n = 1'b0;
        set_alloc(1'b1, 7'd60, 7'd6, 1'b1);
        rob_if.cmp_rob_num[0] = 4'd1;
        tick();
        vectors++;
        if (rob_if.retire_valid !== 1'b0 || rob_if.count !== 5'd0 || rob_if.empty !== 1'b1) begin
            $display("FAIL midreset_state got v=%b count=%0d empty=%b want 0/0/1",
                     rob_if.retire_valid, rob_if.count, rob_if.empty);
            miscompares++;
        end
        rst_n = 1'b1;
        idle();
        tick();
        vectors++;
        if (rob_if.retire_valid !== 1'b0 || rob_if.alloc_rob_num !== 4'd0) begin
            $display("FAIL midreset_after got v=%b num=%0d want 0/0",
                     rob_if.retire_valid, rob_if.alloc_rob_num);
            miscompares++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_single();
        test_out_of_order();
        test_full_wrap();
        test_multi_cmp();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
